// File: rtl/pwm_duty_scheduler_if.sv
// Request/grant and duty-output bundle between the duty requesters and the scheduler.
interface pwm_duty_scheduler_if #(
    parameter int DUTY_W = 2
);
    logic              req_a;
    logic [DUTY_W-1:0] target_a;
    logic              req_b;
    logic [DUTY_W-1:0] target_b;
    logic              grant_a;
    logic              grant_b;
    logic [DUTY_W-1:0] duty_cycle;
    logic              busy;
    logic              period_start;

    modport master (
        output req_a, target_a, req_b, target_b,
        input  grant_a, grant_b, duty_cycle, busy, period_start
    );

    modport slave (
        input  req_a, target_a, req_b, target_b,
        output grant_a, grant_b, duty_cycle, busy, period_start
    );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Round-robin arbiter for two duty requesters that walks duty_cycle one code
// per dwell interval, stepping only on PWM period boundaries.
//
//   state | meaning
//   IDLE  | accepting requests; duty_cycle steady
//   RAMP  | stepping duty_cycle toward target_q, requests ignored
module pwm_duty_scheduler #(
    parameter int PERIOD = 10,
    parameter int DWELL  = 3,
    parameter int DUTY_W = 2
) (
    input logic clk,
    input logic reset,
    pwm_duty_scheduler_if.slave bus
);
    localparam int PCNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PCNT_W-1:0]  PCNT_MAX  = PCNT_W'(PERIOD - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DUTY_W-1:0]  target_q, target_d;
    logic               prio_b_q, prio_b_d;
    logic               grant_a_q, grant_a_d;
    logic               grant_b_q, grant_b_d;
    logic               busy_q, busy_d;
    logic               win_b;
    logic [DUTY_W-1:0]  win_tgt;
    logic [DUTY_W-1:0]  step_val;

    always_comb begin
        state_d   = state_q;
        pcnt_d    = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + 1'b1;
        dwell_d   = dwell_q;
        duty_d    = duty_q;
        target_d  = target_q;
        prio_b_d  = prio_b_q;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        win_b     = 1'b0;
        win_tgt   = '0;
        step_val  = duty_q;

        case (state_q)
            IDLE: begin
                // The cycle right after a grant is skipped so a requester still
                // holding req while it sees its grant is not served twice.
                if ((bus.req_a || bus.req_b) && !(grant_a_q || grant_b_q)) begin
                    win_b     = bus.req_b && (!bus.req_a || prio_b_q);
                    win_tgt   = win_b ? bus.target_b : bus.target_a;
                    grant_a_d = !win_b;
                    grant_b_d = win_b;
                    prio_b_d  = !win_b;
                    target_d  = win_tgt;
                    dwell_d   = DWELL_MAX;
                    if (win_tgt != duty_q) state_d = RAMP;
                end
            end
            RAMP: begin
                if (pcnt_q == '0) begin
                    if (dwell_q == DWELL_MAX) begin
                        step_val = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
                        duty_d   = step_val;
                        dwell_d  = '0;
                        if (step_val == target_q) state_d = IDLE;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            dwell_q   <= '0;
            duty_q    <= '0;
            target_q  <= '0;
            prio_b_q  <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            dwell_q   <= dwell_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            prio_b_q  <= prio_b_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.grant_a      = grant_a_q;
    assign bus.grant_b      = grant_b_q;
    assign bus.duty_cycle   = duty_q;
    assign bus.busy         = busy_q;
    assign bus.period_start = (pcnt_q == '0);
endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler: ramps, arbitration, reset and period alignment.
module tb_pwm_duty_scheduler;
    localparam int PERIOD = 10;
    localparam int DWELL  = 3;
    localparam int SPACING = PERIOD * DWELL;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pwm_duty_scheduler_if #(.DUTY_W(2)) bus ();

    pwm_duty_scheduler #(.PERIOD(PERIOD), .DWELL(DWELL), .DUTY_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent period phase reference.
    int tb_pcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_pcnt <= 0;
        else       tb_pcnt <= (tb_pcnt == PERIOD - 1) ? 0 : tb_pcnt + 1;
    end

    // Continuous invariants: period_start phase, grant exclusivity/spacing, step size and timing.
    logic       mon_valid = 1'b0;
    logic [1:0] prev_duty;
    logic       prev_ps, prev_grant, prev_busy;
    always @(negedge clk) begin
        if (reset) begin
            mon_valid = 1'b0;
        end else begin
            checks++;
            if (bus.period_start !== (tb_pcnt == 0))
                $display("FAIL period_start: got %b want %b (phase %0d)", bus.period_start, (tb_pcnt == 0), tb_pcnt);
            if (bus.period_start !== (tb_pcnt == 0)) errors++;
            checks++;
            if (bus.grant_a === 1'b1 && bus.grant_b === 1'b1) begin
                errors++;
                $display("FAIL grant_overlap: grant_a=%b grant_b=%b want not both", bus.grant_a, bus.grant_b);
            end
            if (mon_valid) begin
                checks++;
                if (bus.duty_cycle !== prev_duty &&
                    (!prev_ps || ((bus.duty_cycle > prev_duty) ? bus.duty_cycle - prev_duty : prev_duty - bus.duty_cycle) != 2'd1)) begin
                    errors++;
                    $display("FAIL duty_step: %0d -> %0d with prev period_start=%b, want +-1 on period_start edge",
                             prev_duty, bus.duty_cycle, prev_ps);
                end
                checks++;
                if ((bus.grant_a || bus.grant_b) && (prev_grant || prev_busy)) begin
                    errors++;
                    $display("FAIL grant_spacing: grant after prev_grant=%b prev_busy=%b, want both 0", prev_grant, prev_busy);
                end
            end
            prev_duty  = bus.duty_cycle;
            prev_ps    = bus.period_start;
            prev_grant = bus.grant_a || bus.grant_b;
            prev_busy  = bus.busy;
            mon_valid  = 1'b1;
        end
    end

    // Ramp observation (data collection only).
    int         step_cyc [0:3];
    logic [1:0] step_val [0:3];
    logic       step_busy[0:3];
    logic       ramp_timeout;

    task automatic follow_ramp(input int n);
        int cnt;
        int waited;
        logic [1:0] last;
        cnt = 0;
        last = bus.duty_cycle;
        ramp_timeout = 1'b0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                cnt++;
                waited++;
            end while (bus.duty_cycle === last && waited < SPACING + PERIOD + 5);
            if (bus.duty_cycle === last) ramp_timeout = 1'b1;
            step_cyc[i]  = cnt;
            step_val[i]  = bus.duty_cycle;
            step_busy[i] = bus.busy;
            last = bus.duty_cycle;
        end
    endtask

    function automatic int first_delay(input int g);
        return (g == 0) ? 1 : PERIOD + 1 - g;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.target_a = 2'd0; bus.target_b = 2'd0;
        #20;
        checks++;
        if (bus.duty_cycle !== 2'd0 || bus.busy !== 1'b0 || bus.grant_a !== 1'b0 || bus.grant_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: duty=%0d busy=%b ga=%b gb=%b want 0 0 0 0",
                     bus.duty_cycle, bus.busy, bus.grant_a, bus.grant_b);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            checks++;
            if (bus.period_start !== (i % PERIOD == 0) || bus.duty_cycle !== 2'd0 || bus.busy !== 1'b0 ||
                bus.grant_a !== 1'b0 || bus.grant_b !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: cycle %0d ps=%b duty=%0d busy=%b ga=%b gb=%b want ps=%b rest 0",
                         i, bus.period_start, bus.duty_cycle, bus.busy, bus.grant_a, bus.grant_b, (i % PERIOD == 0));
            end
        end
    endtask

    task automatic test_single_ramp;
        int g;
        bus.req_a = 1'b1; bus.target_a = 2'd3;
        @(negedge clk);
        g = tb_pcnt;
        checks++;
        if (bus.grant_a !== 1'b1 || bus.grant_b !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL up_grant: ga=%b gb=%b busy=%b want 1 0 1", bus.grant_a, bus.grant_b, bus.busy);
        end
        bus.req_a = 1'b0;
        follow_ramp(3);
        checks++;
        if (ramp_timeout !== 1'b0) begin errors++; $display("FAIL up_timeout: got %b want 0", ramp_timeout); end
        checks++;
        if (step_cyc[0] != first_delay(g)) begin
            errors++; $display("FAIL up_first_step: got %0d cycles want %0d", step_cyc[0], first_delay(g));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (step_val[i] !== 2'(i + 1) || (i > 0 && step_cyc[i] - step_cyc[i-1] != SPACING)) begin
                errors++;
                $display("FAIL up_step%0d: val=%0d at %0d want %0d spaced %0d", i, step_val[i], step_cyc[i], i + 1, SPACING);
            end
        end
        checks++;
        if (step_busy[0] !== 1'b1 || step_busy[1] !== 1'b1 || step_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL up_busy: got %b%b%b want 110", step_busy[0], step_busy[1], step_busy[2]);
        end
    endtask

    task automatic test_ramp_down_noop;
        int g;
        logic bad;
        bus.req_b = 1'b1; bus.target_b = 2'd1;
        @(negedge clk);
        g = tb_pcnt;
        checks++;
        if (bus.grant_b !== 1'b1 || bus.grant_a !== 1'b0) begin
            errors++; $display("FAIL down_grant: ga=%b gb=%b want 0 1", bus.grant_a, bus.grant_b);
        end
        bus.req_b = 1'b0;
        follow_ramp(2);
        checks++;
        if (ramp_timeout !== 1'b0 || step_val[0] !== 2'd2 || step_val[1] !== 2'd1 ||
            step_cyc[0] != first_delay(g) || step_cyc[1] - step_cyc[0] != SPACING || step_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL down_ramp: vals %0d,%0d at %0d,%0d busy_end=%b to=%b want 2,1 at %0d,%0d busy 0",
                     step_val[0], step_val[1], step_cyc[0], step_cyc[1], step_busy[1], ramp_timeout,
                     first_delay(g), first_delay(g) + SPACING);
        end
        bus.req_a = 1'b1; bus.target_a = 2'd1;
        @(negedge clk);
        checks++;
        if (bus.grant_a !== 1'b1 || bus.busy !== 1'b0 || bus.duty_cycle !== 2'd1) begin
            errors++;
            $display("FAIL noop_grant: ga=%b busy=%b duty=%0d want 1 0 1", bus.grant_a, bus.busy, bus.duty_cycle);
        end
        bus.req_a = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.duty_cycle !== 2'd1 || bus.grant_a !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL noop_hold: disturbance=%b want 0", bad); end
    endtask

    task automatic test_contention;
        int g;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        bus.req_a = 1'b1; bus.target_a = 2'd2;
        bus.req_b = 1'b1; bus.target_b = 2'd0;
        @(negedge clk);
        checks++;
        if (bus.grant_a !== 1'b1 || bus.grant_b !== 1'b0) begin
            errors++; $display("FAIL contend_first: ga=%b gb=%b want 1 0", bus.grant_a, bus.grant_b);
        end
        bus.req_a = 1'b0;
        follow_ramp(2);
        checks++;
        if (ramp_timeout !== 1'b0 || step_val[0] !== 2'd1 || step_val[1] !== 2'd2 || step_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL contend_ramp_a: vals %0d,%0d busy_end=%b to=%b want 1,2 0", step_val[0], step_val[1],
                     step_busy[1], ramp_timeout);
        end
        @(negedge clk);
        g = tb_pcnt;
        checks++;
        if (bus.grant_b !== 1'b1 || bus.grant_a !== 1'b0) begin
            errors++; $display("FAIL contend_second: ga=%b gb=%b want 0 1", bus.grant_a, bus.grant_b);
        end
        bus.req_b = 1'b0;
        follow_ramp(2);
        checks++;
        if (ramp_timeout !== 1'b0 || step_val[0] !== 2'd1 || step_val[1] !== 2'd0 ||
            step_cyc[0] != first_delay(g) || step_cyc[1] - step_cyc[0] != SPACING) begin
            errors++;
            $display("FAIL contend_ramp_b: vals %0d,%0d at %0d,%0d to=%b want 1,0 at %0d,%0d", step_val[0],
                     step_val[1], step_cyc[0], step_cyc[1], ramp_timeout, first_delay(g), first_delay(g) + SPACING);
        end
    endtask

    task automatic test_reset_mid_ramp;
        int g;
        @(negedge clk);
        bus.req_a = 1'b1; bus.target_a = 2'd3;
        @(negedge clk);
        checks++;
        if (bus.grant_a !== 1'b1) begin errors++; $display("FAIL mid_grant: ga=%b want 1", bus.grant_a); end
        follow_ramp(2);
        checks++;
        if (ramp_timeout !== 1'b0 || bus.duty_cycle !== 2'd2 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_reach2: duty=%0d busy=%b want 2 1", bus.duty_cycle, bus.busy);
        end
        @(posedge clk); #3 reset = 1'b1;
        #1;
        checks++;
        if (bus.duty_cycle !== 2'd0 || bus.busy !== 1'b0 || bus.grant_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: duty=%0d busy=%b ga=%b want 0 0 0", bus.duty_cycle, bus.busy, bus.grant_a);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.grant_a !== 1'b0 || bus.period_start !== 1'b1) begin
            errors++; $display("FAIL mid_release: ga=%b ps=%b want 0 1", bus.grant_a, bus.period_start);
        end
        @(negedge clk);
        g = tb_pcnt;
        checks++;
        if (bus.grant_a !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_regrant: ga=%b busy=%b want 1 1", bus.grant_a, bus.busy);
        end
        bus.req_a = 1'b0;
        follow_ramp(3);
        checks++;
        if (ramp_timeout !== 1'b0 || step_val[0] !== 2'd1 || step_val[1] !== 2'd2 || step_val[2] !== 2'd3 ||
            step_cyc[0] != first_delay(g)) begin
            errors++;
            $display("FAIL mid_restart: vals %0d,%0d,%0d first %0d to=%b want 1,2,3 first %0d", step_val[0],
                     step_val[1], step_val[2], step_cyc[0], ramp_timeout, first_delay(g));
        end
    endtask

    task automatic test_period_alignment;
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (tb_pcnt != 6 && n < 2 * PERIOD);
        bus.req_b = 1'b1; bus.target_b = 2'd0;
        @(negedge clk);
        checks++;
        if (bus.grant_b !== 1'b1 || tb_pcnt != 7) begin
            errors++; $display("FAIL align_grant: gb=%b phase=%0d want 1 7", bus.grant_b, tb_pcnt);
        end
        bus.req_b = 1'b0;
        follow_ramp(3);
        checks++;
        if (ramp_timeout !== 1'b0 || step_cyc[0] != 4 || step_val[0] !== 2'd2) begin
            errors++;
            $display("FAIL align_first: step at %0d val %0d to=%b want 4 val 2", step_cyc[0], step_val[0], ramp_timeout);
        end
        checks++;
        if (step_val[2] !== 2'd0 || step_cyc[2] - step_cyc[1] != SPACING || step_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL align_end: val %0d gap %0d busy %b want 0 %0d 0", step_val[2],
                     step_cyc[2] - step_cyc[1], step_busy[2], SPACING);
        end
    endtask

    initial begin
        test_reset();
        test_single_ramp();
        test_ramp_down_noop();
        test_contention();
        test_reset_mid_ramp();
        test_period_alignment();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
